// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the core MEM stage and the debug/loader port.
// Core has priority; a starvation counter and a lock input guarantee the debug port its slots.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic {OWN_CORE, OWN_DBG} owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       sel_dbg;
    logic       sel_core;
    owner_t     owner_q;
    owner_t     owner_next;

    // Grants are forced low while clear is held so nothing reaches the RAM during reset.
    always_comb begin
        sel_dbg    = ~clear & dbg_req & (dbg_lock | ~core_req | (wait_cnt == WAIT_LIMIT));
        sel_core   = ~clear & core_req & ~sel_dbg & ~dbg_lock;
        dbg_gnt    = sel_dbg;
        core_stall = ~clear & core_req & ~sel_core;
        core_rdata = mem_dout;
    end

    always_comb begin
        mem_addr = core_addr;
        mem_din  = core_wdata;
        mem_wren = 1'b0;
        if (sel_dbg) begin
            mem_addr = dbg_addr;
            mem_din  = dbg_wdata;
            mem_wren = dbg_we;
        end else if (sel_core) begin
            mem_wren = core_we;
        end
    end

    // Counts consecutive edges where debug asked and was refused.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wait_cnt <= 4'd0;
        end else if (sel_dbg || !dbg_req) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_comb begin
        owner_next = OWN_CORE;
        if (sel_dbg && !dbg_we) begin
            owner_next = OWN_DBG;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            owner_q <= OWN_CORE;
        end else begin
            owner_q <= owner_next;
        end
    end

    // RAM output is valid the cycle after a debug read edge; capture it then.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else if (owner_q == OWN_DBG) begin
            dbg_rvalid <= 1'b1;
            dbg_rdata  <= mem_dout;
        end else begin
            dbg_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic against
// a word-array reference model of the RAM and the arbitration rules.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clock;
    logic              clear;
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_dout;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .clear(clear),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wren(mem_wren), .mem_dout(mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port RAM the arbiter drives (read-first).
    logic [DATA_W-1:0] ram [0:255];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } core_exp_t;

    logic [DATA_W-1:0] mmem [0:255];
    logic [DATA_W-1:0] dbg_q [$];
    core_exp_t         core_q [$];
    int                den;
    int                cyc;
    int                checks;
    int                errors;
    logic              dbg_done;
    logic              core_done;

    task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drives one cycle from the current inputs: predicts grants from the rules, checks them,
    // queues expected read data, then commits the model at the rising edge.
    task automatic apply_stimulus();
        logic              exp_dbg;
        logic              exp_core;
        logic              exp_wren;
        logic [ADDR_W-1:0] exp_addr;
        core_exp_t         ce;
        #1;
        exp_dbg  = dbg_req && (dbg_lock || !core_req || den == MAX_WAIT);
        exp_core = core_req && !exp_dbg && !dbg_lock;
        exp_wren = exp_dbg ? dbg_we : (exp_core ? core_we : 1'b0);
        exp_addr = exp_dbg ? dbg_addr : core_addr;
        check_bit("dbg_gnt", dbg_gnt, exp_dbg);
        check_bit("core_stall", core_stall, core_req && !exp_core);
        check_bit("mem_wren", mem_wren, exp_wren);
        check_output("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (exp_wren) check_output("mem_din", mem_din, exp_dbg ? dbg_wdata : core_wdata);
        if (exp_dbg && !dbg_we) dbg_q.push_back(mmem[dbg_addr]);
        if (exp_core && !core_we) begin
            ce.due  = cyc + 1;
            ce.data = mmem[core_addr];
            core_q.push_back(ce);
        end
        @(posedge clock);
        if (exp_dbg && dbg_we) mmem[dbg_addr] = dbg_wdata;
        else if (exp_core && core_we) mmem[core_addr] = core_wdata;
        if (exp_dbg || !dbg_req) den = 0;
        else if (den < MAX_WAIT) den++;
        cyc++;
        dbg_done  = exp_dbg;
        core_done = exp_core;
        @(negedge clock);
    endtask

    // Monitor: pops expected read data whenever the DUT presents a result.
    always @(negedge clock) begin
        if (!clear) begin
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL dbg_rvalid_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    check_output("dbg_rdata", dbg_rdata, dbg_q.pop_front());
                end
            end
            if (core_q.size() > 0 && core_q[0].due == cyc) begin
                check_output("core_rdata", core_rdata, core_q.pop_front().data);
            end
        end
    end

    task automatic idle();
        core_req = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        apply_stimulus();
    endtask

    int first_gnt;
    int second_gnt;
    int grants;

    initial begin
        checks = 0; errors = 0; den = 0; cyc = 0;
        dbg_done = 1'b1; core_done = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ram[i]  = '0;
            mmem[i] = '0;
        end
        clear = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 32'h1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'h2; dbg_lock = 1'b0;
        repeat (2) @(negedge clock);
        check_bit("reset_dbg_gnt", dbg_gnt, 1'b0);
        check_bit("reset_core_stall", core_stall, 1'b0);
        check_bit("reset_mem_wren", mem_wren, 1'b0);
        check_bit("reset_dbg_rvalid", dbg_rvalid, 1'b0);
        check_output("reset_dbg_rdata", dbg_rdata, '0);
        clear = 1'b0;
        core_req = 1'b0; dbg_req = 1'b0;

        // Core only: write then read back.
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 32'hDEADBEEF;
        apply_stimulus();
        core_we = 1'b0;
        apply_stimulus();
        check_output("core_only_read", core_rdata, 32'hDEADBEEF);
        idle();

        // Debug only: write then read; rvalid pulses once.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'h12345678;
        apply_stimulus();
        dbg_we = 1'b0;
        apply_stimulus();
        dbg_req = 1'b0;
        apply_stimulus();
        check_bit("dbg_only_rvalid", dbg_rvalid, 1'b1);
        check_output("dbg_only_rdata", dbg_rdata, 32'h12345678);
        apply_stimulus();
        check_bit("dbg_only_rvalid_pulse", dbg_rvalid, 1'b0);

        // Contention: debug should win every fifth cycle.
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
        first_gnt = -1; second_gnt = -1;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus();
            if (dbg_done && first_gnt < 0) first_gnt = i;
            else if (dbg_done && second_gnt < 0) second_gnt = i;
        end
        check_output("starve_first_gnt", 32'(first_gnt), 32'(MAX_WAIT));
        check_output("starve_second_gnt", 32'(second_gnt), 32'(2 * MAX_WAIT + 1));
        idle();

        // Lock burst: eight debug writes while the core is held off.
        dbg_lock = 1'b1; core_req = 1'b1; core_we = 1'b0; core_addr = 8'h03;
        grants = 0;
        for (int i = 0; i < 8; i++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'(i); dbg_wdata = 32'hC0DE0000 + 32'(i);
            apply_stimulus();
            if (dbg_done) grants++;
        end
        check_output("lock_grants", 32'(grants), 32'd8);
        dbg_req = 1'b0; dbg_lock = 1'b0;
        apply_stimulus();
        check_output("lock_core_read", core_rdata, 32'hC0DE0003);
        idle();

        // Same-address conflict in the forced debug slot.
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h40; core_wdata = 32'hAAAA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 32'h5555;
        dbg_done = 1'b0;
        for (int i = 0; i < 8 && !dbg_done; i++) apply_stimulus();
        check_bit("conflict_dbg_granted", dbg_done, 1'b1);
        check_output("conflict_ram_dbg", ram[8'h40], 32'h5555);
        dbg_req = 1'b0;
        apply_stimulus();
        check_bit("conflict_core_retry", core_done, 1'b1);
        check_output("conflict_ram_core", ram[8'h40], 32'hAAAA);
        idle();

        // Async reset between a debug read grant and its capture.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
        apply_stimulus();
        clear = 1'b1; core_req = 1'b1; core_we = 1'b1;
        #1;
        check_bit("clear_dbg_gnt", dbg_gnt, 1'b0);
        check_bit("clear_core_stall", core_stall, 1'b0);
        check_bit("clear_mem_wren", mem_wren, 1'b0);
        check_bit("clear_dbg_rvalid", dbg_rvalid, 1'b0);
        check_output("clear_dbg_rdata", dbg_rdata, '0);
        dbg_q.delete();
        den = 0;
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0; core_req = 1'b0; dbg_req = 1'b0;
        apply_stimulus();
        check_bit("post_clear_rvalid0", dbg_rvalid, 1'b0);
        apply_stimulus();
        check_bit("post_clear_rvalid1", dbg_rvalid, 1'b0);

        // Randomized traffic; requesters hold their request until served.
        core_done = 1'b1; dbg_done = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!core_req || core_done) begin
                core_req   = ($urandom % 4) != 0;
                core_we    = 1'($urandom);
                core_addr  = 8'($urandom_range(0, 15));
                core_wdata = $urandom;
            end
            if (!dbg_req || dbg_done) begin
                dbg_req   = ($urandom % 3) == 0;
                dbg_we    = 1'($urandom);
                dbg_addr  = 8'($urandom_range(0, 15));
                dbg_wdata = $urandom;
            end
            if (($urandom % 40) == 0) dbg_lock = ~dbg_lock;
            apply_stimulus();
        end
        repeat (3) idle();
        check_output("dbg_queue_drained", 32'(dbg_q.size()), 32'd0);
        check_output("core_queue_drained", 32'(core_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
